// File: rtl/dispense_arbiter.sv
// Round-robin arbiter that shares one dispenser motor between N_REQ front-ends.
// Each grant runs a fixed motor pulse, then waits for the done sensor or times out into FAULT.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrates unless an ack pulse is still out
// DRIVE | grant held, motor_on high for PULSE_CYCLES clocks
// WAIT  | grant held, motor off, waiting for motor_done or timeout
// FAULT | sensor timed out; everything idle except fault until clear_fault
module dispense_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PULSE_CYCLES = 3,
    parameter int TIMEOUT      = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             motor_done,
    input  logic             clear_fault,
    output logic [N_REQ-1:0] grant,
    output logic             motor_on,
    output logic [N_REQ-1:0] ack,
    output logic             fault,
    output logic [1:0]       state
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_DRIVE = 2'b01;
    localparam logic [1:0] S_WAIT  = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_INIT  = IW'(N_REQ - 1);

    logic [1:0]       state_nxt;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    winner_nxt;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    pick;
    logic             pick_valid;
    logic [PW-1:0]    pulse_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [N_REQ-1:0] grant_nxt;
    logic [N_REQ-1:0] ack_nxt;
    logic [N_REQ-1:0] hot_nxt;
    logic [N_REQ-1:0] hot_cur;

    // Descending scan so the smallest offset from last_grant+1 is the one that sticks.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick       = last_grant;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % N_REQ;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick       = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            winner     <= '0;
            last_grant <= LAST_INIT;
            pulse_cnt  <= '0;
            wait_cnt   <= '0;
            grant      <= '0;
            motor_on   <= 1'b0;
            ack        <= '0;
            fault      <= 1'b0;
        end else begin
            state    <= state_nxt;
            winner   <= winner_nxt;
            grant    <= grant_nxt;
            motor_on <= (state_nxt == S_DRIVE);
            ack      <= ack_nxt;
            fault    <= (state_nxt == S_FAULT);

            if (state != S_DRIVE && state_nxt == S_DRIVE)
                pulse_cnt <= PULSE_LOAD;
            else if (state == S_DRIVE && pulse_cnt != '0)
                pulse_cnt <= pulse_cnt - 1'b1;

            if (state != S_WAIT && state_nxt == S_WAIT)
                wait_cnt <= '0;
            else if (state == S_WAIT && state_nxt == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;

            // Both completion and timeout demote the finishing requester.
            if (state == S_WAIT && state_nxt != S_WAIT)
                last_grant <= winner;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid && ack == '0) state_nxt = S_DRIVE;
            S_DRIVE: if (pulse_cnt == '0) state_nxt = S_WAIT;
            S_WAIT: begin
                if (motor_done)
                    state_nxt = S_IDLE;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = S_FAULT;
            end
            S_FAULT: if (clear_fault) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        winner_nxt      = (state == S_IDLE) ? pick : winner;
        hot_nxt         = '0;
        hot_nxt[winner_nxt] = 1'b1;
        hot_cur         = '0;
        hot_cur[winner] = 1'b1;
        grant_nxt = (state_nxt == S_DRIVE || state_nxt == S_WAIT) ? hot_nxt : '0;
        ack_nxt   = (state == S_WAIT && motor_done) ? hot_cur : '0;
    end

endmodule
